// File: rtl/bridge_pkg.sv
// Shared types and defaults for the CPU-to-peripheral bridge (sys_bridge).
// Holds the FSM state enum, the address type and the window-match helper.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic [31:0] addr_t;

  localparam int unsigned DEF_WIN_BYTES = 12;
  localparam int unsigned DEF_TO_CYCLES = 255;

  // Offset form avoids wrap-around when a window sits at the top of the map.
  function automatic logic in_window(addr_t addr, addr_t base, int unsigned win);
    return (addr >= base) && ((addr - base) < addr_t'(win));
  endfunction

endpackage

// File: rtl/bridge_decode.sv
// Address decoder for sys_bridge: maps a byte address to a one-hot channel
// hit vector; overlapping windows resolve to the lowest channel index.
module bridge_decode
  import bridge_pkg::*;
#(
  parameter int                NCH       = 4,
  parameter logic [NCH*32-1:0] BASE_LIST = '0,
  parameter int unsigned       WIN_BYTES = DEF_WIN_BYTES
) (
  input  logic [31:0]    addr,
  output logic [NCH-1:0] hit_vec,
  output logic           hit
);

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    hit_vec = '0;
    // Descending scan: a lower index found later overwrites a higher one.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (in_window(addr, BASE_LIST[i*32 +: 32], WIN_BYTES)) begin
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
      end
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/sys_bridge.sv
// CPU request to NCH peripheral-channel bridge: IDLE -> ACCESS -> RESP.
// Define BRIDGE_TIMEOUT_EN to add an 8-bit ack timeout in ACCESS.
module sys_bridge
  import bridge_pkg::*;
#(
  parameter int                NCH       = 4,
  parameter logic [NCH*32-1:0] BASE_LIST = {32'h7f30, 32'h7f20, 32'h7f10, 32'h7f00},
  parameter int unsigned       WIN_BYTES = DEF_WIN_BYTES,
  parameter int unsigned       TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_byteen,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [NCH-1:0]    dev_sel,
  output logic [31:0]       dev_addr,
  output logic [3:0]        dev_byteen,
  output logic [31:0]       dev_wdata,
  input  logic [NCH*32-1:0] dev_rdata,
  input  logic [NCH-1:0]    dev_ack
);

  state_t         state;
  logic [NCH-1:0] hit_vec;
  logic           hit;
  logic [31:0]    sel_rdata;
  logic           sel_ack;

`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] to_cnt;
`endif

  bridge_decode #(
    .NCH       (NCH),
    .BASE_LIST (BASE_LIST),
    .WIN_BYTES (WIN_BYTES)
  ) u_decode (
    .addr    (req_addr),
    .hit_vec (hit_vec),
    .hit     (hit)
  );

  // dev_sel is one-hot, so an OR of the gated lanes is the selected lane.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (dev_sel[i]) sel_rdata |= dev_rdata[i*32 +: 32];
    end
  end

  assign sel_ack = |(dev_ack & dev_sel);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      dev_sel    <= '0;
      dev_addr   <= '0;
      dev_byteen <= '0;
      dev_wdata  <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (hit) begin
              state      <= ACCESS;
              dev_sel    <= hit_vec;
              dev_addr   <= req_addr;
              dev_byteen <= req_byteen;
              dev_wdata  <= req_wdata;
`ifdef BRIDGE_TIMEOUT_EN
              to_cnt     <= '0;
`endif
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end

        ACCESS: begin
          if (sel_ack) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= (dev_byteen == 4'd0) ? sel_rdata : '0;
            dev_sel   <= '0;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (to_cnt == 8'(TO_CYCLES - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            dev_sel   <= '0;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end

        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          dev_sel   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bridge.sv
// Self-checking bench for sys_bridge: directed vector table, randomized
// transactions against an address-map model, reset and overlap sequences.
module tb_sys_bridge;

  localparam int NCH   = 4;
  localparam int BOUND = 600;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    int          ack_delay;
    logic [31:0] ack_data;
    logic [3:0]  exp_sel;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr, req_wdata;
  logic [3:0]   req_byteen;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [3:0]   dev_sel, dev_byteen, dev_ack;
  logic [31:0]  dev_addr, dev_wdata;
  logic [127:0] dev_rdata;

  logic         o_req_valid, o_req_ready;
  logic [31:0]  o_req_addr, o_req_wdata;
  logic [3:0]   o_req_byteen;
  logic         o_rsp_valid, o_rsp_err;
  logic [31:0]  o_rsp_rdata;
  logic [3:0]   o_dev_sel, o_dev_byteen, o_dev_ack;
  logic [31:0]  o_dev_addr, o_dev_wdata;
  logic [127:0] o_dev_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  vec_t tbl[10];
  int unsigned bases[4] = '{32'h7f00, 32'h7f10, 32'h7f20, 32'h7f30};

  sys_bridge #(.NCH(NCH)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_byteen (req_byteen),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dev_sel    (dev_sel),
    .dev_addr   (dev_addr),
    .dev_byteen (dev_byteen),
    .dev_wdata  (dev_wdata),
    .dev_rdata  (dev_rdata),
    .dev_ack    (dev_ack)
  );

  sys_bridge #(
    .NCH       (NCH),
    .BASE_LIST ({32'h7f30, 32'h7f10, 32'h7f10, 32'h7f00})
  ) u_ovl (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (o_req_valid),
    .req_ready  (o_req_ready),
    .req_addr   (o_req_addr),
    .req_byteen (o_req_byteen),
    .req_wdata  (o_req_wdata),
    .rsp_valid  (o_rsp_valid),
    .rsp_rdata  (o_rsp_rdata),
    .rsp_err    (o_rsp_err),
    .dev_sel    (o_dev_sel),
    .dev_addr   (o_dev_addr),
    .dev_byteen (o_dev_byteen),
    .dev_wdata  (o_dev_wdata),
    .dev_rdata  (o_dev_rdata),
    .dev_ack    (o_dev_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input int dly, input logic [31:0] data,
                              input logic [3:0] sel, input logic err,
                              input logic [31:0] rd, input int lat);
    vec_t v;
    v.addr = addr; v.byteen = be; v.wdata = wd; v.ack_delay = dly; v.ack_data = data;
    v.exp_sel = sel; v.exp_err = err; v.exp_rdata = rd; v.exp_lat = lat;
    return v;
  endfunction

  // Address-map reference: first window (lowest channel) containing the address wins.
  function automatic vec_t model(input vec_t v);
    int ch = -1;
    longint a = longint'(v.addr);
    for (int c = 0; c < 4; c++)
      if (ch < 0 && a >= longint'(bases[c]) && a < longint'(bases[c]) + 12) ch = c;
    if (ch < 0) begin
      v.exp_sel = 4'd0; v.exp_err = 1'b1; v.exp_rdata = 32'd0; v.exp_lat = 1;
    end else begin
      v.exp_sel   = 4'd1 << ch;
      v.exp_err   = 1'b0;
      v.exp_rdata = (v.byteen == 4'd0) ? v.ack_data : 32'd0;
      v.exp_lat   = 2 + v.ack_delay;
    end
    return v;
  endfunction

  function automatic int lane(input logic [3:0] s);
    int l = 0;
    for (int i = 0; i < 4; i++) if (s[i]) l = i;
    return l;
  endfunction

  // Entered and left at posedge+1 with the bridge idle.
  task automatic run_txn(input vec_t v);
    int  n;
    bit  got;
    logic [3:0] noise;
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_addr   = v.addr;
    req_byteen = v.byteen;
    req_wdata  = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n   = 1;
    got = 0;
    while (!got && n <= BOUND) begin
      if (rsp_valid) begin
        got = 1;
        check("latency", n, v.exp_lat);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("sel_in_resp", {28'd0, dev_sel}, 32'd0);
        check("ready_resp", {31'd0, req_ready}, 32'd0);
      end else begin
        check("dev_sel", {28'd0, dev_sel}, {28'd0, v.exp_sel});
        if (n == 1) begin
          check("dev_addr", dev_addr, v.addr);
          check("dev_byteen", {28'd0, dev_byteen}, {28'd0, v.byteen});
          check("dev_wdata", dev_wdata, v.wdata);
        end
        dev_rdata = {$urandom, $urandom, $urandom, $urandom};
        noise = ~v.exp_sel & 4'($urandom);
        if (n == v.ack_delay + 1) begin
          dev_ack = v.exp_sel | noise;
          dev_rdata[lane(v.exp_sel)*32 +: 32] = v.ack_data;
        end else begin
          dev_ack = noise;
        end
      end
      @(posedge clk); #1;
      dev_ack = '0;
      n++;
    end
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
    check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    check("ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic idle_acks_ignored(input string name);
    for (int i = 0; i < 3; i++) begin
      dev_ack = 4'hf;
      @(posedge clk); #1;
      check(name, {31'd0, rsp_valid}, 32'd0);
    end
    dev_ack = '0;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_byteen = '0; req_wdata = '0;
    dev_rdata = '0; dev_ack = '0;
    o_req_valid = 1'b0; o_req_addr = '0; o_req_byteen = '0; o_req_wdata = '0;
    o_dev_rdata = '0; o_dev_ack = '0;

    tbl[0] = mk(32'h7f04, 4'h0, 32'h0,  0, 32'h1234,     4'b0001, 1'b0, 32'h1234,     2);
    tbl[1] = mk(32'h7f18, 4'hf, 32'hAA, 0, 32'h5a5a,     4'b0010, 1'b0, 32'h0,        2);
    tbl[2] = mk(32'h7f0c, 4'h0, 32'h0,  0, 32'h0,        4'b0000, 1'b1, 32'h0,        1);
    tbl[3] = mk(32'h7f00, 4'h0, 32'h0,  2, 32'hdeadbeef, 4'b0001, 1'b0, 32'hdeadbeef, 4);
    tbl[4] = mk(32'h7f0b, 4'h0, 32'h0,  1, 32'h55,       4'b0001, 1'b0, 32'h55,       3);
    tbl[5] = mk(32'h7f3b, 4'h1, 32'h9,  0, 32'h77,       4'b1000, 1'b0, 32'h0,        2);
    tbl[6] = mk(32'h7f3c, 4'h0, 32'h0,  0, 32'h0,        4'b0000, 1'b1, 32'h0,        1);
    tbl[7] = mk(32'h7eff, 4'h0, 32'h0,  0, 32'h0,        4'b0000, 1'b1, 32'h0,        1);
    tbl[8] = mk(32'h7f0c, 4'h3, 32'h1,  0, 32'h0,        4'b0000, 1'b1, 32'h0,        1);
`ifdef BRIDGE_TIMEOUT_EN
    tbl[9] = mk(32'h7f20, 4'h0, 32'h0, 400, 32'hcafe,    4'b0100, 1'b1, 32'h0,      256);
`else
    tbl[9] = mk(32'h7f20, 4'h0, 32'h0, 300, 32'hcafe,    4'b0100, 1'b0, 32'hcafe,   302);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_dev_sel", {28'd0, dev_sel}, 32'd0);
    check("rst_dev_addr", dev_addr, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);
    idle_acks_ignored("late_ack_ignored");

    for (int i = 0; i < 40; i++) begin
      v.addr      = $urandom_range(32'h7f50, 32'h7ef0);
      v.byteen    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      v.wdata     = $urandom;
      v.ack_delay = $urandom_range(0, 3);
      v.ack_data  = $urandom;
      run_txn(model(v));
    end

    // Reset in the middle of ACCESS drops the request silently.
    req_valid = 1'b1; req_addr = 32'h7f04; req_byteen = 4'h0; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_sel_before_rst", {28'd0, dev_sel}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_sel", {28'd0, dev_sel}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_dev_addr", dev_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_acks_ignored("mid_rst_no_rsp");
    run_txn(tbl[0]);

    // Overlapping windows: ch1 and ch2 share a base, ch1 must win.
    o_req_valid = 1'b1; o_req_addr = 32'h7f10; o_req_byteen = 4'h0;
    @(posedge clk); #1;
    o_req_valid = 1'b0;
    check("ovl_sel", {28'd0, o_dev_sel}, 32'd2);
    o_dev_ack = 4'b0010;
    o_dev_rdata[32 +: 32] = 32'h0ff1;
    o_dev_rdata[64 +: 32] = 32'h0bad;
    @(posedge clk); #1;
    o_dev_ack = '0;
    check("ovl_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    check("ovl_rsp_rdata", o_rsp_rdata, 32'h0ff1);
    check("ovl_rsp_err", {31'd0, o_rsp_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
